// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_drain
// Description : Drains a registered-output FIFO into a valid/ready stream via
//               a 3-entry skid buffer, framing beats into PKT_LEN packets.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [7:0]       beat_cnt,
    output logic [15:0]      pkt_cnt
);

    localparam int         c_depth     = 3;
    localparam logic [7:0] c_last_beat = 8'(PKT_LEN - 1);

    logic [WIDTH-1:0] r_buf [c_depth];
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [7:0]       r_beat;
    logic [15:0]      r_pkt;

    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_occ_nxt;
    logic [1:0]       w_wr_idx;

    assign w_push    = r_inflight;
    assign w_pop     = m_valid && m_ready;
    assign w_occ_nxt = {1'b0, r_occ} + {2'b00, w_push} - {2'b00, w_pop};
    // Slot for the returning word, measured after this cycle's shift-out.
    assign w_wr_idx  = r_occ - {1'b0, w_pop};

    // Credit counts the in-flight word so the buffer can always absorb it.
    assign fifo_rd_en = rst_n && en && !fifo_empty &&
                        (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);

    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_buf[0];
    assign m_last   = m_valid && (r_beat == c_last_beat);
    assign beat_cnt = r_beat;
    assign pkt_cnt  = r_pkt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_beat     <= 8'd0;
            r_pkt      <= 16'd0;
            for (int i = 0; i < c_depth; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_nxt[1:0];
            if (w_pop) begin
                for (int i = 0; i < c_depth - 1; i++) begin
                    r_buf[i] <= r_buf[i+1];
                end
                r_beat <= m_last ? 8'd0 : r_beat + 8'd1;
                if (m_last) begin
                    r_pkt <= r_pkt + 16'd1;
                end
            end
            // Placed after the shift so a simultaneous push lands in the freed slot.
            if (w_push) begin
                r_buf[w_wr_idx] <= fifo_dout;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (w_occ_nxt <= 3'd3) && !(w_push && (r_occ == 2'd3) && !w_pop));

endmodule
`default_nettype wire
